nodf_handshake_monitor: RTL and testbench
=========================================

Name: nodf_handshake_monitor

Overview:
- Passive, synthesizable observer for one non-dataflow HLS block's ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue).
- Tracks per-block execution state and counts transactions, latency and ready pulses.
- One instance per monitored block; a simulation-level collector reads its outputs at end of run.
- Never drives the monitored block.

Parameters:
- CNT_W, 32, width of every cycle counter and latency register.
- TXN_W, 16, width of the transaction and ready-pulse counters.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- ap_start  input  1  observed start request of the monitored block.
- ap_ready  input  1  observed ready (inputs consumed) pulse.
- ap_done  input  1  observed completion.
- ap_continue  input  1  observed downstream acceptance; tie 1 when the block has none.
- finish  input  1  end-of-simulation strobe; freezes the monitor.
- state  output  2  0 IDLE, 1 RUN, 2 DONE_HOLD, 3 FROZEN.
- txn_count  output  TXN_W  completed transactions.
- ready_count  output  TXN_W  cycles with ap_ready=1, counted independently of state.
- cur_latency  output  CNT_W  cycles elapsed in the current transaction.
- last_latency  output  CNT_W  latency of the most recent completed transaction.
- max_latency  output  CNT_W  largest completed latency.
- busy_cycles  output  CNT_W  total cycles spent in RUN or DONE_HOLD.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clock edge): state IDLE; all counters and latency registers 0. Reset wins over every other input, including while FROZEN.
- IDLE:
  - ap_start=0: stay IDLE.
  - ap_start=1 and ap_done=0: go to RUN, cur_latency=1.
  - ap_start=1 and ap_done=1 in the same cycle (zero-wait block): a latency-1 transaction.
    - With ap_continue=1: complete it (see completion); stay IDLE.
    - With ap_continue=0: go to DONE_HOLD.
- RUN:
  - cur_latency increments each cycle; busy_cycles increments.
  - ap_done=1 and ap_continue=1: complete. Next state is RUN (cur_latency=1) if ap_start=1 the same cycle, otherwise IDLE (cur_latency=0).
  - ap_done=1 and ap_continue=0: go to DONE_HOLD.
- DONE_HOLD:
  - cur_latency holds; busy_cycles increments.
  - ap_continue=1: complete, then leave by the same rule as RUN.
- Completion, in one cycle:
  - txn_count+1.
  - last_latency = latency including the completing cycle.
  - max_latency = max(max_latency, that latency).
- ready_count increments on every cycle with ap_ready=1, in any non-FROZEN state. This covers blocks whose start/done are tied 0.
- finish=1 in any state: next state FROZEN; all counters hold forever until reset. The finish cycle itself is not counted.
- Saturation: every counter saturates at all-ones and never wraps. max_latency compares using the saturated value.
- ap_done while IDLE with ap_start=0 is ignored (no transaction).

Optional Feature:
- Macro NODF_PROTOCOL_CHECK_EN.
- When defined, adds:
  - output err_flags [2:0], sticky until reset.
  - bit0: ap_done seen in IDLE without ap_start.
  - bit1: ap_start deasserted while in RUN before ap_ready was seen.
  - bit2: ap_done seen while in DONE_HOLD (double done).
- Flags also freeze on finish.
- When not defined: no err_flags port and no check logic.

Decomposition:
- Package nodf_mon_pkg holds the state enum typedef (IDLE/RUN/DONE_HOLD/FROZEN) and the default width constants.
- One natural sub-module: nodf_sat_counter (parameterised width, inc/clear/hold, saturating), reused for all counters.

Test Plan:
- Reset with reset=0 for 2 cycles, all inputs random -> state=0 and all counters 0.
- ap_start at cycle 0, ap_done with ap_continue=1 at cycle 4 -> txn_count=1, last_latency=5, max_latency=5, busy_cycles=5, state IDLE.
- Back-to-back transactions: ap_start held, ap_done every 3rd cycle, 4 completions -> txn_count=4, last_latency=3, state remains RUN.
- ap_done with ap_continue=0 for 3 cycles, then ap_continue=1 -> state 2 for 3 cycles, last_latency excludes hold cycles, busy_cycles includes them.
- Only ap_ready pulsed 7 times (start/done tied 0) -> ready_count=7, txn_count=0, state IDLE.
- Pulse finish mid-RUN, keep toggling inputs -> state=3, counters frozen; reset=0 -> all cleared.

Source files
------------

// File: rtl/nodf_mon_pkg.sv
// Shared types and default widths for the non-dataflow ap_ctrl handshake monitor.
package nodf_mon_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int TXN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_HOLD = 2'd2,
    FROZEN    = 2'd3
  } mon_state_e;
endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// clr_i restarts the count, and inc_i in the same cycle counts that cycle as 1.
module nodf_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = {{(W-1){1'b0}}, inc_i};
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/nodf_handshake_monitor.sv
// Passive observer of one ap_ctrl handshake: execution state, transaction/latency stats.
// Define NODF_PROTOCOL_CHECK_EN to add sticky protocol error flags (err_flags).
module nodf_handshake_monitor
  import nodf_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TXN_W = TXN_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
`ifdef NODF_PROTOCOL_CHECK_EN
  output logic [2:0]       err_flags,
`endif
  output logic [1:0]       state,
  output logic [TXN_W-1:0] txn_count,
  output logic [TXN_W-1:0] ready_count,
  output logic [CNT_W-1:0] cur_latency,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] busy_cycles
);
  mon_state_e       state_q, state_d;
  logic             comp, cur_clr, cur_inc, busy_inc, ready_inc;
  logic [CNT_W-1:0] comp_lat, cur_plus;
  logic [CNT_W-1:0] last_q, max_q;

  assign cur_plus = (&cur_latency) ? cur_latency : cur_latency + 1'b1;

  // The start cycle is latency cycle 1 and also the first busy cycle.
  always_comb begin
    state_d  = state_q;
    comp     = 1'b0;
    cur_clr  = 1'b0;
    cur_inc  = 1'b0;
    busy_inc = 1'b0;
    comp_lat = '0;
    case (state_q)
      IDLE: if (ap_start) begin
        busy_inc = 1'b1;
        comp_lat = {{(CNT_W-1){1'b0}}, 1'b1};
        if (ap_done && ap_continue) begin
          comp = 1'b1;
        end else begin
          state_d = ap_done ? DONE_HOLD : RUN;
          cur_clr = 1'b1;
          cur_inc = 1'b1;
        end
      end
      RUN: begin
        busy_inc = 1'b1;
        cur_inc  = 1'b1;
        comp_lat = cur_plus;
        if (ap_done && ap_continue) begin
          comp    = 1'b1;
          cur_clr = 1'b1;
          cur_inc = ap_start;
          state_d = ap_start ? RUN : IDLE;
        end else if (ap_done) begin
          state_d = DONE_HOLD;
        end
      end
      DONE_HOLD: begin
        busy_inc = 1'b1;
        comp_lat = cur_latency;
        if (ap_continue) begin
          comp    = 1'b1;
          cur_clr = 1'b1;
          cur_inc = ap_start;
          state_d = ap_start ? RUN : IDLE;
        end
      end
      FROZEN: ;
    endcase
    if (finish) begin
      state_d  = FROZEN;
      comp     = 1'b0;
      cur_clr  = 1'b0;
      cur_inc  = 1'b0;
      busy_inc = 1'b0;
    end
  end

  assign ready_inc = ap_ready && state_q != FROZEN && !finish;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      if (comp) begin
        last_q <= comp_lat;
        if (comp_lat > max_q) max_q <= comp_lat;
      end
    end
  end

  nodf_sat_counter #(.W(TXN_W)) u_txn (
    .clock(clock), .reset(reset), .clr_i(1'b0), .inc_i(comp), .cnt_o(txn_count));
  nodf_sat_counter #(.W(TXN_W)) u_rdy (
    .clock(clock), .reset(reset), .clr_i(1'b0), .inc_i(ready_inc), .cnt_o(ready_count));
  nodf_sat_counter #(.W(CNT_W)) u_cur (
    .clock(clock), .reset(reset), .clr_i(cur_clr), .inc_i(cur_inc), .cnt_o(cur_latency));
  nodf_sat_counter #(.W(CNT_W)) u_busy (
    .clock(clock), .reset(reset), .clr_i(1'b0), .inc_i(busy_inc), .cnt_o(busy_cycles));

  assign state        = state_q;
  assign last_latency = last_q;
  assign max_latency  = max_q;

`ifdef NODF_PROTOCOL_CHECK_EN
  logic [2:0] err_q, err_d;
  logic       rdy_seen_q, rdy_seen_d;

  // rdy_seen tracks whether the current transaction has consumed its inputs yet.
  always_comb begin
    err_d      = err_q;
    rdy_seen_d = rdy_seen_q;
    if (state_q != FROZEN && !finish) begin
      if (state_q == IDLE && ap_done && !ap_start)                   err_d[0] = 1'b1;
      if (state_q == RUN && !ap_start && !(rdy_seen_q || ap_ready)) err_d[1] = 1'b1;
      if (state_q == DONE_HOLD && ap_done)                           err_d[2] = 1'b1;
      if (cur_clr)       rdy_seen_d = cur_inc & ap_ready;
      else if (ap_ready) rdy_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_q      <= '0;
      rdy_seen_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      rdy_seen_q <= rdy_seen_d;
    end
  end

  assign err_flags = err_q;
`endif
endmodule

// File: tb/tb_nodf_handshake_monitor.sv
// Directed scoreboard bench for nodf_handshake_monitor (narrow widths to reach saturation).
module tb_nodf_handshake_monitor;
  localparam int CW = 5;
  localparam int TW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0;
  logic          ap_continue = 1'b1, finish = 1'b0;
  logic [1:0]    state;
  logic [TW-1:0] txn_count, ready_count;
  logic [CW-1:0] cur_latency, last_latency, max_latency, busy_cycles;
`ifdef NODF_PROTOCOL_CHECK_EN
  logic [2:0]    err_flags;
`endif

  nodf_handshake_monitor #(.CNT_W(CW), .TXN_W(TW)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish),
`ifdef NODF_PROTOCOL_CHECK_EN
    .err_flags(err_flags),
`endif
    .state(state), .txn_count(txn_count), .ready_count(ready_count),
    .cur_latency(cur_latency), .last_latency(last_latency),
    .max_latency(max_latency), .busy_cycles(busy_cycles));

  always #5 clock = ~clock;

  typedef struct {
    int st, txn, rdy, cur, last, mx, busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk_req = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", n, f, act, exp);
    end
  endtask

  // Monitor: pops one expected snapshot each time a check is presented.
  always @(negedge clock) begin
    exp_t  e;
    string n;
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: check presented with empty queue");
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        cmp(n, "state",        32'(state),        e.st);
        cmp(n, "txn_count",    32'(txn_count),    e.txn);
        cmp(n, "ready_count",  32'(ready_count),  e.rdy);
        cmp(n, "cur_latency",  32'(cur_latency),  e.cur);
        cmp(n, "last_latency", 32'(last_latency), e.last);
        cmp(n, "max_latency",  32'(max_latency),  e.mx);
        cmp(n, "busy_cycles",  32'(busy_cycles),  e.busy);
      end
    end
  end

  task automatic step(input logic s, input logic r, input logic d, input logic c, input logic f);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
    @(posedge clock);
    #1;
  endtask

  task automatic rstep();
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic chk(input string n, input int st, input int txn, input int rdy,
                     input int cur, input int last, input int mx, input int busy);
    exp_t e;
    e.st = st; e.txn = txn; e.rdy = rdy; e.cur = cur; e.last = last; e.mx = mx; e.busy = busy;
    exp_q.push_back(e);
    name_q.push_back(n);
    chk_req = 1'b1;
    @(negedge clock);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(0, 0, 0, 1, 0);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset under random inputs.
    reset = 1'b0;
    repeat (2) rstep();
    reset = 1'b1;
    chk("reset", 0, 0, 0, 0, 0, 0, 0);

    // Single transaction: start at cycle 0, done+continue at cycle 4.
    step(1, 1, 0, 1, 0);         chk("a_start", 1, 0, 1, 1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1, 0); chk("a_run", 1, 0, 1, 4, 0, 0, 4);
    step(0, 0, 1, 1, 0);         chk("a_done", 0, 1, 1, 0, 5, 5, 5);
    step(0, 0, 1, 1, 0);         chk("a_idle_done_ignored", 0, 1, 1, 0, 5, 5, 5);
    do_reset();                  chk("rst_clear", 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back: start held, done on the 3rd cycle of each transaction
    // (the completing cycle also starts the next one).
    step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0); step(1, 0, 1, 1, 0);
    chk("b2b_1", 1, 1, 0, 1, 3, 3, 3);
    repeat (3) begin step(1, 0, 0, 1, 0); step(1, 0, 1, 1, 0); end
    chk("b2b_4", 1, 4, 0, 1, 3, 3, 9);
    step(0, 0, 1, 1, 0);         chk("b2b_short_max_holds", 0, 5, 0, 0, 2, 3, 10);
    do_reset();

    // Done held off by ap_continue=0 for 3 cycles.
    step(1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);         chk("hold_1", 2, 0, 0, 2, 0, 0, 2);
    step(0, 0, 1, 0, 0);         chk("hold_2", 2, 0, 0, 2, 0, 0, 3);
    step(0, 0, 1, 0, 0);         chk("hold_3", 2, 0, 0, 2, 0, 0, 4);
    step(0, 0, 1, 1, 0);         chk("hold_release", 0, 1, 0, 0, 2, 2, 5);
    step(1, 0, 1, 1, 0);         chk("zero_wait", 0, 2, 0, 0, 1, 2, 6);
    step(1, 0, 1, 0, 0);         chk("zero_wait_hold", 2, 2, 0, 1, 1, 2, 7);
    step(1, 0, 0, 1, 0);         chk("hold_restart", 1, 3, 0, 1, 1, 2, 8);
    step(0, 0, 1, 1, 0);         chk("restart_done", 0, 4, 0, 0, 2, 2, 9);
    do_reset();

    // Ready-only block: 7 pulses, then an 8th must saturate at 7.
    repeat (7) begin step(0, 1, 0, 1, 0); step(0, 0, 0, 1, 0); end
    chk("ready_7", 0, 0, 7, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);         chk("ready_sat", 0, 0, 7, 0, 0, 0, 0);
    do_reset();

    // Latency and busy saturate at 31.
    step(1, 0, 0, 1, 0);
    repeat (40) step(0, 0, 0, 1, 0);
    chk("lat_sat", 1, 0, 0, 31, 0, 0, 31);
    step(0, 0, 1, 1, 0);         chk("lat_sat_done", 0, 1, 0, 0, 31, 31, 31);
    do_reset();

    // Finish mid-RUN: the finish cycle is not counted, then everything holds.
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1);         chk("frz", 3, 0, 1, 2, 0, 0, 2);
    repeat (6) rstep();          chk("frz_hold", 3, 0, 1, 2, 0, 0, 2);
    reset = 1'b0;
    rstep();
    reset = 1'b1;
    chk("frz_reset", 0, 0, 0, 0, 0, 0, 0);

    step(0, 0, 0, 1, 0);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
